// File: rtl/draw_sequencer.sv
// Draw-command sequencer: start-point load, x/y scan with plot, frame hold, done.
// Optional pre-clear pass to black is enabled with DRAW_SEQ_CLEAR_FIRST_EN.
module draw_sequencer #(
    parameter logic [24:0] FRAME_HOLD = 25'd12500000,
    parameter logic [14:0] WATCHDOG   = 15'd20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic [4:0] xSelIn,
    input  logic [1:0] ySelIn,
    input  logic [4:0] memSelIn,
    input  logic       screenDone,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [4:0] xInitSel,
    output logic [1:0] yInitSel,
    output logic       xInitLoad,
    output logic       yInitLoad,
    output logic [1:0] xySel,
    output logic       xLoad,
    output logic       yLoad,
    output logic       xCountUp,
    output logic       yCountUp,
    output logic [4:0] memorySel,
    output logic       plot
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_INIT = 3'd1,
        LOAD_XY   = 3'd2,
        PLOT      = 3'd3,
        HOLD      = 3'd4,
        FINISH    = 3'd5
`ifdef DRAW_SEQ_CLEAR_FIRST_EN
        ,
        CLR_XY    = 3'd6,
        CLR_PLOT  = 3'd7
`endif
    } state_t;

    localparam logic [14:0] WD_LAST    = WATCHDOG - 15'd1;
    localparam logic [4:0]  BLACK_SEL  = 5'd1;

    state_t      state;
    logic        modeLat;
    logic [4:0]  memSelLat;
    logic        scanLoad;
    logic        plotPhase;
    logic [14:0] wdCount;
    logic [24:0] holdCount;

    logic        wdExpired;
    logic        holdLast;
    logic        pixelWrite;

    assign wdExpired = (wdCount == WD_LAST);
    assign holdLast  = (26'(holdCount) + 26'd1) >= 26'(FRAME_HOLD);

    // NOTE: plot and the scan loads are gated combinationally by screenDone and the
    // watchdog so the cycle that ends a pass never issues an extra VGA write.
    assign pixelWrite = plotPhase && !screenDone && !wdExpired;
    assign plot       = pixelWrite;
    assign xLoad      = scanLoad || pixelWrite;
    assign yLoad      = scanLoad || pixelWrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            modeLat   <= 1'b0;
            memSelLat <= 5'd0;
            xInitSel  <= 5'd0;
            yInitSel  <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            xInitLoad <= 1'b0;
            yInitLoad <= 1'b0;
            scanLoad  <= 1'b0;
            plotPhase <= 1'b0;
            xySel     <= 2'b00;
            memorySel <= 5'd0;
            xCountUp  <= 1'b0;
            yCountUp  <= 1'b0;
            wdCount   <= 15'd0;
            holdCount <= 25'd0;
        end else begin
            // NOTE: non-blocking assignments throughout; done is a pulse that
            // defaults low every cycle and is raised only on entry to FINISH.
            done <= 1'b0;

            // Shared scan-pass bookkeeping: leave the pass on screenDone or watchdog expiry.
            if (plotPhase) begin
                if (screenDone || wdExpired) begin
                    plotPhase <= 1'b0;
                    xCountUp  <= 1'b0;
                    yCountUp  <= 1'b0;
                    xySel     <= 2'b00;
                    memorySel <= 5'd0;
                end else begin
                    wdCount <= wdCount + 15'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        modeLat   <= mode;
                        memSelLat <= memSelIn;
                        xInitSel  <= xSelIn;
                        yInitSel  <= ySelIn;
                        timeout   <= 1'b0;
                        busy      <= 1'b1;
                        xInitLoad <= 1'b1;
                        yInitLoad <= 1'b1;
                        state     <= LOAD_INIT;
                    end
                end
                LOAD_INIT: begin
                    xInitLoad <= 1'b0;
                    yInitLoad <= 1'b0;
                    scanLoad  <= 1'b1;
`ifdef DRAW_SEQ_CLEAR_FIRST_EN
                    state     <= CLR_XY;
`else
                    state     <= LOAD_XY;
`endif
                end
                LOAD_XY: begin
                    scanLoad  <= 1'b0;
                    wdCount   <= 15'd0;
                    plotPhase <= 1'b1;
                    xCountUp  <= 1'b1;
                    yCountUp  <= 1'b1;
                    xySel     <= modeLat ? 2'b10 : 2'b01;
                    memorySel <= memSelLat;
                    state     <= PLOT;
                end
                PLOT: begin
                    if (screenDone) begin
                        holdCount <= 25'd0;
                        state     <= HOLD;
                    end else if (wdExpired) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= FINISH;
                    end
                end
                HOLD: begin
                    if (holdLast) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (holdCount != '1) begin
                        holdCount <= holdCount + 25'd1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`ifdef DRAW_SEQ_CLEAR_FIRST_EN
                CLR_XY: begin
                    scanLoad  <= 1'b0;
                    wdCount   <= 15'd0;
                    plotPhase <= 1'b1;
                    xCountUp  <= 1'b1;
                    yCountUp  <= 1'b1;
                    xySel     <= modeLat ? 2'b10 : 2'b01;
                    memorySel <= BLACK_SEL;
                    state     <= CLR_PLOT;
                end
                CLR_PLOT: begin
                    if (screenDone) begin
                        scanLoad <= 1'b1;
                        state    <= LOAD_XY;
                    end else if (wdExpired) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= FINISH;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: a behavioural scan datapath drives screenDone, and
// expected pixels / completions are queued at command issue and popped as they appear.
module tb_draw_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstA, rstB, startA, startB, mode;
    logic [4:0] xSelIn, memSelIn;
    logic [1:0] ySelIn;

    logic       busyA, doneA, timeoutA, xInitLoadA, yInitLoadA, xLoadA, yLoadA;
    logic       xCountUpA, yCountUpA, plotA, screenDoneA;
    logic [4:0] xInitSelA, memorySelA;
    logic [1:0] yInitSelA, xySelA;

    logic       busyB, doneB, timeoutB, xInitLoadB, yInitLoadB, xLoadB, yLoadB;
    logic       xCountUpB, yCountUpB, plotB;
    logic       screenDoneB = 1'b0;
    logic [4:0] xInitSelB, memorySelB;
    logic [1:0] yInitSelB, xySelB;

    draw_sequencer #(.FRAME_HOLD(25'd4), .WATCHDOG(15'd20000)) dutA (
        .clk(clk), .reset(rstA), .start(startA), .mode(mode), .xSelIn(xSelIn),
        .ySelIn(ySelIn), .memSelIn(memSelIn), .screenDone(screenDoneA),
        .busy(busyA), .done(doneA), .timeout(timeoutA), .xInitSel(xInitSelA),
        .yInitSel(yInitSelA), .xInitLoad(xInitLoadA), .yInitLoad(yInitLoadA),
        .xySel(xySelA), .xLoad(xLoadA), .yLoad(yLoadA), .xCountUp(xCountUpA),
        .yCountUp(yCountUpA), .memorySel(memorySelA), .plot(plotA)
    );

    draw_sequencer #(.FRAME_HOLD(25'd0), .WATCHDOG(15'd100)) dutB (
        .clk(clk), .reset(rstB), .start(startB), .mode(mode), .xSelIn(xSelIn),
        .ySelIn(ySelIn), .memSelIn(memSelIn), .screenDone(screenDoneB),
        .busy(busyB), .done(doneB), .timeout(timeoutB), .xInitSel(xInitSelB),
        .yInitSel(yInitSelB), .xInitLoad(xInitLoadB), .yInitLoad(yInitLoadB),
        .xySel(xySelB), .xLoad(xLoadB), .yLoad(yLoadB), .xCountUp(xCountUpB),
        .yCountUp(yCountUpB), .memorySel(memorySelB), .plot(plotB)
    );

    int nCompared = 0;
    int nMismatch = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp)
        else begin
            nMismatch++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in scan datapath: start-point lookup, x/y scan registers, screenDone.
    function automatic int spanW(input logic [1:0] s); return (s == 2'b10) ? 40 : 160; endfunction
    function automatic int spanH(input logic [1:0] s); return (s == 2'b10) ? 40 : 120; endfunction
    function automatic int xOrigin(input logic [4:0] s); return (s == 5'd0) ? 0 : 11 + 10 * int'(s); endfunction
    function automatic int yOrigin(input logic [1:0] s); return (s == 2'd0) ? 0 : 1 + 30 * int'(s); endfunction

    int xInitA = 0, yInitA = 0, xA = 0, yA = 0;
    always @(posedge clk) begin
        if (xInitLoadA) xInitA <= xOrigin(xInitSelA);
        if (yInitLoadA) yInitA <= yOrigin(yInitSelA);
        if (xLoadA && xySelA == 2'b00) begin
            xA <= xInitA;
            yA <= yInitA;
        end else if (plotA) begin
            if (xA == xInitA + spanW(xySelA) - 1) begin
                xA <= xInitA;
                yA <= yA + 1;
            end else begin
                xA <= xA + 1;
            end
        end
    end
    assign screenDoneA = (xySelA != 2'b00) && (yA == yInitA + spanH(xySelA));

    typedef struct { int plots; logic tmo; int gap; } done_t;
    done_t       doneQA[$];
    done_t       doneQB[$];
    logic [21:0] pixQ[$];
    bit          scoreOn = 1'b1;
    int          plotsA = 0, plotsB = 0, lastPlotA = 0, lastPlotB = 0;
    int          doneSeenA = 0, doneSeenB = 0;

    task automatic pushPixels(input int xs, input int ys, input int w, input int h,
                              input logic [4:0] mem, input logic [1:0] sel);
        for (int y = ys; y < ys + h; y++)
            for (int x = xs; x < xs + w; x++)
                pixQ.push_back({8'(x), 7'(y), mem, sel});
    endtask

    always @(negedge clk) begin
        done_t e;
        if (plotA) begin
            plotsA++;
            lastPlotA = cyc;
            if (scoreOn) begin
                if (pixQ.size() == 0) check("pixel_extra", plotA, 1'b0);
                else check("pixel", {xA[7:0], yA[6:0], memorySelA, xySelA}, pixQ.pop_front());
            end
            if (screenDoneA) check("plot_on_screenDone", plotA, 1'b0);
        end
        if (doneA) begin
            doneSeenA++;
            if (doneQA.size() == 0) check("done_extra_A", doneA, 1'b0);
            else begin
                e = doneQA.pop_front();
                check("plots_A", plotsA, e.plots);
                check("timeout_A", timeoutA, e.tmo);
                check("gap_A", cyc - lastPlotA, e.gap);
            end
            plotsA = 0;
        end
        if (plotB) begin
            plotsB++;
            lastPlotB = cyc;
        end
        if (doneB) begin
            doneSeenB++;
            if (doneQB.size() == 0) check("done_extra_B", doneB, 1'b0);
            else begin
                e = doneQB.pop_front();
                check("plots_B", plotsB, e.plots);
                check("timeout_B", timeoutB, e.tmo);
                check("gap_B", cyc - lastPlotB, e.gap);
            end
            plotsB = 0;
        end
    end

    task automatic waitIdle(input bit useB, input int budget, input string tag);
        int n = 0;
        while ((useB ? busyB : busyA) === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, useB ? busyB : busyA, 1'b0);
    endtask

    initial begin
        int cnt;
        int n;
        rstA = 1'b1; rstB = 1'b1; startA = 1'b1; startB = 1'b0;
        mode = 1'b1; xSelIn = 5'b01000; ySelIn = 2'b01; memSelIn = 5'd12;
        repeat (3) @(negedge clk);

        // Held in reset with start high.
        check("rst_busy", busyA, 1'b0);
        check("rst_done", doneA, 1'b0);
        check("rst_timeout", timeoutA, 1'b0);
        check("rst_plot", plotA, 1'b0);
        check("rst_xInitLoad", xInitLoadA, 1'b0);
        check("rst_xLoad", xLoadA, 1'b0);
        check("rst_xySel", xySelA, 2'b00);
        check("rst_memorySel", memorySelA, 5'd0);
        check("rst_xInitSel", xInitSelA, 5'd0);
        check("rst_busyB", busyB, 1'b0);

        // Tile draw, issued by releasing reset with start already high.
        pushPixels(91, 31, 40, 40, 5'd12, 2'b10);
        doneQA.push_back('{plots: 1600, tmo: 1'b0, gap: 6});
        rstA = 1'b0; rstB = 1'b0;
        @(negedge clk);
        check("li_xInitLoad", xInitLoadA, 1'b1);
        check("li_yInitLoad", yInitLoadA, 1'b1);
        check("li_busy", busyA, 1'b1);
        check("li_xInitSel", xInitSelA, 5'b01000);
        check("li_yInitSel", yInitSelA, 2'b01);
        check("li_plot", plotA, 1'b0);
        startA = 1'b0;
        @(negedge clk);
        check("lxy_xLoad", xLoadA, 1'b1);
        check("lxy_yLoad", yLoadA, 1'b1);
        check("lxy_xySel", xySelA, 2'b00);
        check("lxy_plot", plotA, 1'b0);
        check("lxy_xInitLoad", xInitLoadA, 1'b0);
        @(negedge clk);
        check("first_plot", plotA, 1'b1);
        check("first_xySel", xySelA, 2'b10);

        // Start pulsed mid-scan with another colour must be ignored.
        repeat (10) @(negedge clk);
        memSelIn = 5'd5; startA = 1'b1;
        @(negedge clk);
        startA = 1'b0; memSelIn = 5'd12;
        waitIdle(1'b0, 3000, "tile_idle");
        repeat (5) @(negedge clk);
        check("tile_done_count", doneSeenA, 1);
        check("tile_pix_left", pixQ.size(), 0);

        // Full-screen draw.
        mode = 1'b0; xSelIn = 5'd0; ySelIn = 2'd0; memSelIn = 5'd2;
        pushPixels(0, 0, 160, 120, 5'd2, 2'b01);
        doneQA.push_back('{plots: 19200, tmo: 1'b0, gap: 6});
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        waitIdle(1'b0, 25000, "full_idle");
        check("full_done_count", doneSeenA, 2);
        check("full_pix_left", pixQ.size(), 0);
        check("full_timeout", timeoutA, 1'b0);

        // Watchdog abort on a scan that never finishes, then timeout cleared by next start.
        mode = 1'b1; xSelIn = 5'b01000; ySelIn = 2'b01; memSelIn = 5'd7;
        doneQB.push_back('{plots: 99, tmo: 1'b1, gap: 2});
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        waitIdle(1'b1, 500, "wd_idle");
        check("wd_timeout_sticky", timeoutB, 1'b1);
        check("wd_done_count", doneSeenB, 1);
        doneQB.push_back('{plots: 99, tmo: 1'b1, gap: 2});
        startB = 1'b1;
        @(negedge clk);
        check("wd_timeout_cleared", timeoutB, 1'b0);
        startB = 1'b0;
        waitIdle(1'b1, 500, "wd2_idle");
        check("wd2_done_count", doneSeenB, 2);

        // Reset asserted on the 50th plot of a tile draw.
        scoreOn = 1'b0;
        mode = 1'b1; memSelIn = 5'd12;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        cnt = 0;
        n = 0;
        while (cnt < 50 && n < 500) begin
            @(negedge clk);
            n++;
            if (plotA) cnt++;
        end
        check("reached_50th_plot", cnt, 50);
        rstA = 1'b1;
        #1;
        check("mid_rst_plot", plotA, 1'b0);
        check("mid_rst_busy", busyA, 1'b0);
        check("mid_rst_memorySel", memorySelA, 5'd0);
        check("mid_rst_timeout", timeoutA, 1'b0);
        @(negedge clk);
        rstA = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", doneSeenA, 2);
        check("mid_rst_idle", busyA, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- FSM that sequences one draw command through the pixel datapath: the x/y start-point registers, the x/y scan registers with their screenDone flag, and the colour source mux.
- A requester (game FSM) issues a command: full-screen image or 40x40 battle tile, plus start-point selects and a colour-memory select.
- The block loads the start point, scans every pixel while asserting plot for the VGA write, holds for an animation frame delay, then pulses done.
- Includes a watchdog that aborts a scan which never reports screenDone.

Parameters:
- FRAME_HOLD, 25'd12500000, cycles idle after a scan before done (animation pacing); 0 means no hold.
- WATCHDOG, 15'd20000, maximum PLOT cycles before abort; must exceed 161*121.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- mode  in  1  0 = full screen (xySel 01), 1 = 40x40 tile (xySel 10).
- xSelIn  in  5  xInitSel value for the command.
- ySelIn  in  2  yInitSel value for the command.
- memSelIn  in  5  colour source for the command.
- screenDone  in  1  from the scan datapath; combinational.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at command completion.
- timeout  out  1  sticky error flag; set on watchdog abort, cleared on next accepted start.
- xInitSel  out  5  latched command value.
- yInitSel  out  2  latched command value.
- xInitLoad  out  1  start-point register load enable.
- yInitLoad  out  1  start-point register load enable.
- xySel  out  2  scan mode to the scan datapath.
- xLoad  out  1  x scan register load enable.
- yLoad  out  1  y scan register load enable.
- xCountUp  out  1  x scan advance.
- yCountUp  out  1  y scan advance.
- memorySel  out  5  colour mux select.
- plot  out  1  VGA write enable for the current x/y/colour.

Behaviour:
- Reset (async): state IDLE; all outputs 0; command latches 0; counters 0.
- States: IDLE, LOAD_INIT, LOAD_XY, PLOT, HOLD, FINISH.
- IDLE: if start=1, latch mode/xSelIn/ySelIn/memSelIn, clear timeout, go to LOAD_INIT. start while busy is ignored; no queueing.
- LOAD_INIT (1 cycle): xInitLoad=yInitLoad=1, with xInitSel/yInitSel driven from the latches. Go to LOAD_XY.
- LOAD_XY (1 cycle): xySel=00, xLoad=yLoad=1, so x/y take the registered xInit/yInit. Clear the watchdog counter. Go to PLOT.
- PLOT:
  - xySel = mode ? 10 : 01; memorySel = latched memSel.
  - xCountUp=yCountUp=1; xLoad=yLoad=plot=!screenDone.
  - When screenDone=1 in a cycle: no plot and no load that cycle; go to HOLD.
  - Watchdog counter increments each PLOT cycle. If it reaches WATCHDOG-1 with screenDone still 0: set timeout, drop plot, go to FINISH (skip HOLD).
  - screenDone and watchdog expiry in the same cycle: screenDone wins; timeout stays 0.
- HOLD: all enables 0; the hold counter counts FRAME_HOLD cycles, then go to FINISH. With FRAME_HOLD=0, HOLD lasts exactly 1 cycle.
- FINISH (1 cycle): done=1, busy=1. Next state IDLE. start is accepted again from the following cycle.
- memorySel is 0 outside PLOT (and outside the clear pass, when the optional feature is enabled). xySel is 00 outside PLOT.
- Latency, start to first plot: 3 cycles (LOAD_INIT, LOAD_XY, first PLOT cycle).
- plot count equals the datapath pixel count; the controller adds no extra write.
- Counter widths:
  - Hold counter: 25 bits, saturating.
  - Watchdog counter: 15 bits; it cannot wrap before comparison.
- Reset mid-operation: immediate return to IDLE. No done pulse; timeout is cleared.

Optional Feature:
- Macro: DRAW_SEQ_CLEAR_FIRST_EN.
- Defined: after LOAD_INIT, a clear pass runs first: states CLR_XY then CLR_PLOT.
  - Same scan as PLOT, but memorySel=5'd1 (constant-black entry of the colour mux).
  - On screenDone, go to LOAD_XY and run the normal pass.
  - The watchdog is reset at the start of each pass.
  - Start-to-first-plot latency becomes 3 cycles, landing in CLR_PLOT.
- Undefined: states absent; behaviour exactly as above.

Test Plan:
- Reset check: hold reset with start=1 -> all outputs 0 and busy=0. Release reset -> LOAD_INIT follows on the next edge with start=1.
- Tile draw: FRAME_HOLD=4, start with mode=1, xSelIn=5'b01000, ySelIn=01, memSelIn=5'd12 -> xInitLoad pulse, then a LOAD_XY pulse with xySel=00, then plot for every (x,y) in 91..130 x 31..70 (1600 plots) with memorySel=12, then 4 HOLD cycles, then a single done pulse.
- Full screen: start with mode=0, memSelIn=2 -> xySel=01 throughout PLOT; plot deasserts the cycle screenDone rises; busy=0 after FINISH.
- Busy ignore: pulse start again during PLOT with a different memSelIn=5 -> memorySel stays 12; exactly one done pulse.
- Watchdog: tie screenDone=0, WATCHDOG=100 -> exactly 99 plots, timeout=1, done pulse, no HOLD. The next start clears timeout.
- Mid-op reset: assert reset on the 50th plot -> plot, busy and memorySel go 0 asynchronously; no done pulse.
